alu_op_sequencer: RTL

- Synthesizable initiator for cv32e40p_alu: accepts operation requests (op, a, b, tag) on a valid/ready port, drives the ALU input side, holds operands while the ALU is busy, captures result/comparison, returns a tagged response on a second valid/ready port.
- Serves as bring-up harness and self-test front end for the EX-stage ALU; one request outstanding at a time.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_checker.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for alu_op_sequencer. Opcode encodings mirror the cv32e40p_pkg
// alu_opcode_e values so the sequencer can drive a cv32e40p_alu directly.
package alu_seq_pkg;

  localparam int ALU_OP_WIDTH       = 7;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_SLTU = 7'b0000011,
    ALU_AND  = 7'b0010101,
    ALU_ADD  = 7'b0011000,
    ALU_SUB  = 7'b0011001,
    ALU_OR   = 7'b0101110,
    ALU_XOR  = 7'b0101111,
    ALU_DIVU = 7'b0110000,
    ALU_DIV  = 7'b0110001,
    ALU_REMU = 7'b0110010,
    ALU_REM  = 7'b0110011
  } alu_opcode_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seq_state_e;

endpackage

// File: rtl/alu_seq_checker.sv
// Golden model for ADD/SUB results captured by the sequencer, with a
// saturating mismatch counter. Only built when ALU_SEQ_CHECK_EN is defined.
module alu_seq_checker
  import alu_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap,
  input  logic                    clr,
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [31:0]             a,
  input  logic [31:0]             b,
  input  logic [31:0]             result,
  output logic                    mismatch,
  output logic [15:0]             err_cnt
);

  logic [31:0] gold;
  logic        checked;
  logic        miss;

  always_comb begin
    gold    = (op == ALU_SUB) ? a - b : a + b;
    checked = (op == ALU_ADD) || (op == ALU_SUB);
    miss    = checked && (result != gold);
  end

  // mismatch is set at capture so it is valid for the whole response window
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else if (cap) begin
      mismatch <= miss;
      if (miss && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
    end else if (clr) begin
      mismatch <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-outstanding request/response front end for cv32e40p_alu.
// Optional golden-model checking enabled by defining ALU_SEQ_CHECK_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ALU_OP_WIDTH-1:0] req_op_i,
  input  logic [31:0]             req_a_i,
  input  logic [31:0]             req_b_i,
  input  logic [TAG_W-1:0]        req_tag_i,
  output logic [ALU_OP_WIDTH-1:0] alu_operator_o,
  output logic [31:0]             alu_operand_a_o,
  output logic [31:0]             alu_operand_b_o,
  output logic                    alu_enable_o,
  output logic                    alu_ex_ready_o,
  input  logic [31:0]             alu_result_i,
  input  logic                    alu_cmp_i,
  input  logic                    alu_ready_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_result_o,
  output logic                    rsp_cmp_o,
  output logic [TAG_W-1:0]        rsp_tag_o,
`ifdef ALU_SEQ_CHECK_EN
  output logic                    chk_mismatch_o,
  output logic [15:0]             chk_err_cnt_o,
`endif
  output logic                    rsp_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  seq_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic             cap;

  assign cap = ((state == ISSUE) || (state == WAIT)) && alu_ready_i;

  // Combinational so a multicycle unit sees ex_ready in the same cycle it
  // raises ready_o and can retire without an extra stall.
  assign alu_ex_ready_o = (state != WAIT) || alu_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      req_ready_o     <= 1'b1;
      rsp_valid_o     <= 1'b0;
      rsp_result_o    <= '0;
      rsp_cmp_o       <= 1'b0;
      rsp_tag_o       <= '0;
      rsp_err_o       <= 1'b0;
      alu_enable_o    <= 1'b0;
      alu_operator_o  <= ALU_SLTU;
      alu_operand_a_o <= '0;
      alu_operand_b_o <= '0;
      tag_q           <= '0;
      cnt             <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid_i) begin
          alu_operator_o  <= req_op_i;
          alu_operand_a_o <= req_a_i;
          alu_operand_b_o <= req_b_i;
          tag_q           <= req_tag_i;
          alu_enable_o    <= 1'b1;
          req_ready_o     <= 1'b0;
          state           <= ISSUE;
        end
        ISSUE, WAIT: begin
          if (alu_ready_i) begin
            rsp_result_o <= alu_result_i;
            rsp_cmp_o    <= alu_cmp_i;
            rsp_err_o    <= 1'b0;
            rsp_tag_o    <= tag_q;
            rsp_valid_o  <= 1'b1;
            state        <= RESP;
          end else if (state == ISSUE) begin
            cnt   <= CNT_W'(1);
            state <= WAIT;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_result_o <= '0;
            rsp_cmp_o    <= 1'b0;
            rsp_err_o    <= 1'b1;
            rsp_tag_o    <= tag_q;
            rsp_valid_o  <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o  <= 1'b0;
          alu_enable_o <= 1'b0;
          req_ready_o  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  alu_seq_checker u_chk (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .clr      ((state == RESP) && rsp_ready_i),
    .op       (alu_operator_o),
    .a        (alu_operand_a_o),
    .b        (alu_operand_b_o),
    .result   (alu_result_i),
    .mismatch (chk_mismatch_o),
    .err_cnt  (chk_err_cnt_o)
  );
`endif

endmodule
